// File: rtl/seven_seg_if.sv
// ---------------------------------------------------------------------------
// seven_seg_if
//   Bundle between a display source (master) and the 7-segment scan driver
//   (slave). The master supplies the digit data and the scan enable; the
//   slave returns the board-level pin values and the frame tick.
//
//   load        master->slave  capture value/dp_in/lz_blank into pending buffer
//   value       master->slave  4*DIGITS hex nibbles, digit 0 rightmost
//   dp_in       master->slave  per-digit decimal point, 1 = lit
//   lz_blank    master->slave  leading-zero blanking enable (taken with load)
//   enable      master->slave  0 = all anodes inactive
//   seg         slave->master  {g,f,e,d,c,b,a} pin levels
//   dp          slave->master  decimal point pin level
//   an          slave->master  one-hot anode select pin levels
//   frame_tick  slave->master  1-cycle pulse on the first cycle of a frame
// ---------------------------------------------------------------------------
interface seven_seg_if #(
   parameter int DIGITS = 4
);
   logic                load;
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp_in;
   logic                lz_blank;
   logic                enable;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame_tick;

   modport master (
      output load, value, dp_in, lz_blank, enable,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  load, value, dp_in, lz_blank, enable,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexed hex driver for a DIGITS-wide 7-segment display with
//   full 0-F decode, per-digit decimal points, leading-zero blanking and a
//   double-buffered (tear-free) frame update.
//
//   clk   in  single rising-edge clock
//   rst   in  synchronous reset, active-high
//   bus   seven_seg_if.slave: load/value/dp_in/lz_blank/enable in,
//         seg/dp/an/frame_tick out (all outputs registered)
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int REFRESH_DIV    = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input logic        clk,
   input logic        rst,
   seven_seg_if.slave bus
);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   // One displayable frame: digit nibbles, decimal points, blanking enable.
   typedef struct packed {
      logic [4*DIGITS-1:0] value;
      logic [DIGITS-1:0]   dp;
      logic                lz;
   } frame_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      case (n)
         4'h0:    return 7'h3F;
         4'h1:    return 7'h06;
         4'h2:    return 7'h5B;
         4'h3:    return 7'h4F;
         4'h4:    return 7'h66;
         4'h5:    return 7'h6D;
         4'h6:    return 7'h7D;
         4'h7:    return 7'h07;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h6F;
         4'hA:    return 7'h77;
         4'hB:    return 7'h7C;
         4'hC:    return 7'h39;
         4'hD:    return 7'h5E;
         4'hE:    return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   logic [DIV_W-1:0]  div_q, div_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   frame_t            pend_q, pend_d;
   frame_t            act_q, act_d;
   logic              pend_flag_q, pend_flag_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              frame_tick_q, frame_tick_d;

   frame_t            in_frame;
   logic              wrap, boundary;
   logic [3:0]        nib;
   logic              dp_bit, blank, zero_above;
   logic [6:0]        seg_hi;
   logic [DIGITS-1:0] an_hi;

   assign in_frame = '{value: bus.value, dp: bus.dp_in, lz: bus.lz_blank};
   assign wrap     = (div_q == DIV_LAST);
   assign boundary = wrap && (idx_q == IDX_LAST);

   // NOTE: every always_comb output gets a default before any branch, so no
   // path can leave a signal unassigned and infer a latch.
   always_comb begin
      div_d       = wrap ? '0 : div_q + 1'b1;
      idx_d       = idx_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      act_d       = act_q;

      if (wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      if (bus.load) begin
         pend_d      = in_frame;
         pend_flag_d = 1'b1;
      end

      // Active only moves at a frame boundary; a load landing on the
      // boundary itself bypasses the pending buffer so it is not a frame late.
      if (boundary && (pend_flag_q || bus.load)) begin
         act_d       = bus.load ? in_frame : pend_q;
         pend_flag_d = 1'b0;
      end
   end

   // Digit selection and blanking. zero_above accumulates from the most
   // significant digit down, so at digit i it is set only if lz is on and
   // nibbles i..DIGITS-1 are all zero.
   always_comb begin
      nib        = 4'h0;
      dp_bit     = 1'b0;
      blank      = 1'b0;
      an_hi      = '0;
      zero_above = act_q.lz;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (act_q.value[4*i +: 4] == 4'h0);
         if (idx_q == IDX_W'(i)) begin
            nib      = act_q.value[4*i +: 4];
            dp_bit   = act_q.dp[i];
            blank    = zero_above && (i != 0);
            an_hi[i] = bus.enable;
         end
      end
      seg_hi = blank ? 7'h00 : hex_to_seg(nib);

      // Pin polarity is applied only here, at the output register inputs.
      seg_d        = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_d         = SEG_ACTIVE_LOW ? ~dp_bit : dp_bit;
      an_d         = AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
      frame_tick_d = boundary;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q        <= '0;
         idx_q        <= '0;
         pend_q       <= '0;
         act_q        <= '0;
         pend_flag_q  <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= SEG_ACTIVE_LOW;
         an_q         <= AN_ACTIVE_LOW ? '1 : '0;
         frame_tick_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         act_q        <= act_d;
         pend_flag_q  <= pend_flag_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//   Directed bench for seven_seg_scan_driver with DIGITS=4, REFRESH_DIV=4 and
//   active-low segments and anodes. Expected pin values are hand-decoded.
//   Scan positions p = 1..16 count cycles after a frame_tick sample: digit
//   (p-1)/4 is shown, and frame_tick is expected again at p = 16.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   seven_seg_if #(.DIGITS(4)) bus ();

   seven_seg_scan_driver #(
      .DIGITS        (4),
      .REFRESH_DIV   (4),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] dpi, input logic lz);
      bus.value    = v;
      bus.dp_in    = dpi;
      bus.lz_blank = lz;
      bus.load     = 1'b1;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, " an"}, bus.an, 4'b1111);
      chk({name, " seg"}, bus.seg, 7'h7F);
      chk({name, " dp"}, bus.dp, 1'b1);
      chk({name, " frame_tick"}, bus.frame_tick, 1'b0);
   endtask

   // Steps positions from_p..to_p, checking every output each cycle.
   // s0..s3 are active-low segment patterns, dp_lit is active-high per digit.
   task automatic scan(input string name, input int from_p, input int to_p,
                       input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3,
                       input logic [3:0] dp_lit, input logic en);
      logic [6:0] segs [4];
      logic [3:0] an_exp;
      logic       dp_exp;
      logic       ft_exp;
      int         d;
      segs[0] = s0;
      segs[1] = s1;
      segs[2] = s2;
      segs[3] = s3;
      for (int p = from_p; p <= to_p; p++) begin
         tick();
         bus.load = 1'b0;
         d      = (p - 1) / 4;
         an_exp = en ? an_tab[d] : 4'b1111;
         dp_exp = !dp_lit[d];
         ft_exp = (p == 16);
         chk($sformatf("%s an p%0d", name, p), bus.an, an_exp);
         chk($sformatf("%s seg p%0d", name, p), bus.seg, segs[d]);
         chk($sformatf("%s dp p%0d", name, p), bus.dp, dp_exp);
         chk($sformatf("%s frame_tick p%0d", name, p), bus.frame_tick, ft_exp);
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.load     = 1'b0;
      bus.value    = '0;
      bus.dp_in    = '0;
      bus.lz_blank = 1'b0;
      bus.enable   = 1'b1;

      // 1: reset held three cycles, then all digits show '0'
      repeat (3) tick();
      check_reset_outputs("rst");
      rst = 1'b0;

      // 2: 1234 loaded early in frame 0, displayed from the next frame
      pulse_load(16'h1234, 4'b0000, 1'b0);
      scan("s1_zero", 1, 16, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);
      scan("s2_1234", 1, 16, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b1);
      scan("s2_rep", 1, 16, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b1);

      // 3: ABCD loaded while digit 1 is lit; no tearing within the frame
      scan("s3_pre", 1, 5, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b1);
      pulse_load(16'hABCD, 4'b0000, 1'b0);
      scan("s3_hold", 6, 16, 7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 1'b1);
      scan("s3_abcd", 1, 16, 7'h21, 7'h46, 7'h03, 7'h08, 4'b0000, 1'b1);

      // 4: leading-zero blanking on 0070, then on 0000
      pulse_load(16'h0070, 4'b0000, 1'b1);
      scan("s4_pre", 1, 16, 7'h21, 7'h46, 7'h03, 7'h08, 4'b0000, 1'b1);
      scan("s4_0070", 1, 16, 7'h40, 7'h78, 7'h7F, 7'h7F, 4'b0000, 1'b1);
      pulse_load(16'h0000, 4'b0000, 1'b1);
      scan("s4_hold", 1, 16, 7'h40, 7'h78, 7'h7F, 7'h7F, 4'b0000, 1'b1);
      scan("s4_0000", 1, 16, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1);

      // 5: load on the boundary cycle goes straight into the new frame
      scan("s5_pre", 1, 15, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1);
      pulse_load(16'h00F0, 4'b0000, 1'b0);
      scan("s5_bnd", 16, 16, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000, 1'b1);
      scan("s5_f0", 1, 16, 7'h40, 7'h0E, 7'h40, 7'h40, 4'b0000, 1'b1);

      // 5: enable=0 blanks anodes but the scan and frame_tick keep running
      bus.enable = 1'b0;
      pulse_load(16'h00F0, 4'b0010, 1'b0);
      scan("s5_dis", 1, 16, 7'h40, 7'h0E, 7'h40, 7'h40, 4'b0000, 1'b0);
      bus.enable = 1'b1;
      scan("s5_dp", 1, 16, 7'h40, 7'h0E, 7'h40, 7'h40, 4'b0010, 1'b1);

      // 6: reset mid-frame discards a pending load
      pulse_load(16'h5555, 4'b0000, 1'b0);
      scan("s6_pre", 1, 3, 7'h40, 7'h0E, 7'h40, 7'h40, 4'b0010, 1'b1);
      rst = 1'b1;
      repeat (2) tick();
      check_reset_outputs("s6_rst");
      rst = 1'b0;
      scan("s6_post", 1, 16, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);
      scan("s6_next", 1, 16, 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
